pardcore_ctrl_regs: RTL and testbench

AXI4-Lite control/status register slave that sits directly upstream of the `pardcore` instance and generates its static controls. It drives the `nohype_settings` bits. It generates per-core active-low resets with a programmable-length hold. It latches the DMA `mm2s`/`s2mm` interrupt edges into sticky, write-1-to-clear status with a combined interrupt output. It replaces the loose GPIO wiring between the Zynq PS and `pardcore` with one register-mapped block on the PS AXI-Lite master.

---
 rtl/pardcore_ctrl_regs.sv | 172 +++++++++++++++++
 tb/tb_pardcore_ctrl_regs.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pardcore_ctrl_regs.sv
// AXI4-Lite register slave driving pardcore static controls, per-core reset holds and sticky DMA interrupts.
// One write and one read in flight; B/R responses are registered and held until accepted.
module pardcore_ctrl_regs #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          RST_CYCLES = 16,
  parameter logic [31:0] ID_VALUE   = 32'h5041_5244
) (
  input  logic                  coreclk,
  input  logic                  corersts,
  input  logic [ADDR_WIDTH-1:0] s_axilite_awaddr,
  input  logic                  s_axilite_awvalid,
  output logic                  s_axilite_awready,
  input  logic [31:0]           s_axilite_wdata,
  input  logic [3:0]            s_axilite_wstrb,
  input  logic                  s_axilite_wvalid,
  output logic                  s_axilite_wready,
  output logic [1:0]            s_axilite_bresp,
  output logic                  s_axilite_bvalid,
  input  logic                  s_axilite_bready,
  input  logic [ADDR_WIDTH-1:0] s_axilite_araddr,
  input  logic                  s_axilite_arvalid,
  output logic                  s_axilite_arready,
  output logic [31:0]           s_axilite_rdata,
  output logic [1:0]            s_axilite_rresp,
  output logic                  s_axilite_rvalid,
  input  logic                  s_axilite_rready,
  output logic [2:0]            nohype_settings,
  output logic [1:0]            corerstn,
  input  logic [1:0]            intrs,
  output logic                  irq
);
  localparam int              CW          = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0]   RST_LOAD    = CW'(RST_CYCLES);
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;

  logic                  awready_r, wready_r, bvalid_r, rvalid_r;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [5:0]            wdata_q;
  logic                  wstrb0_q;
  logic [1:0]            bresp_r, rresp_r;
  logic [31:0]           rdata_r;
  logic [2:0]            nh_r;
  logic [1:0]            irq_en;
  logic [CW-1:0]         cnt [2];
  logic [1:0]            corerstn_r, intrs_q, rise_q, status;
  logic                  irq_r;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [5:0]            wdat;
  logic                  wstrb0, wr_bad, wr_en, rd_bad, ctrl_wr;
  logic [1:0]            wr_sel, rd_sel, rst_set, clr;
  logic [31:0]           rd_val;
  logic                  unused_ok;

  assign aw_hs  = s_axilite_awvalid & awready_r;
  assign w_hs   = s_axilite_wvalid & wready_r;
  assign ar_hs  = s_axilite_arvalid & ~rvalid_r;
  // A beat counts as present if it handshakes now or was captured earlier.
  assign commit = (aw_hs | ~awready_r) & (w_hs | ~wready_r) & ~bvalid_r;

  assign waddr   = aw_hs ? s_axilite_awaddr : awaddr_q;
  assign wdat    = w_hs ? s_axilite_wdata[5:0] : wdata_q;
  assign wstrb0  = w_hs ? s_axilite_wstrb[0] : wstrb0_q;
  assign wr_bad  = |waddr[ADDR_WIDTH-1:4];
  assign wr_sel  = waddr[3:2];
  assign wr_en   = commit & ~wr_bad & wstrb0;
  assign ctrl_wr = wr_en && (wr_sel == 2'd0);
  assign rst_set = (wr_en && (wr_sel == 2'd1)) ? wdat[1:0] : 2'b00;
  assign clr     = (wr_en && (wr_sel == 2'd2)) ? wdat[1:0] : 2'b00;

  assign rd_bad = |s_axilite_araddr[ADDR_WIDTH-1:4];
  assign rd_sel = s_axilite_araddr[3:2];

  always_comb begin
    rd_val = '0;
    if (!rd_bad) begin
      case (rd_sel)
        2'd0:    rd_val = {26'd0, irq_en, 1'b0, nh_r};
        2'd1:    rd_val = {30'd0, ~corerstn_r};
        2'd2:    rd_val = {30'd0, status};
        default: rd_val = ID_VALUE;
      endcase
    end
  end

  always_ff @(posedge coreclk) begin
    if (corersts) begin
      awready_r  <= 1'b1;
      wready_r   <= 1'b1;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      rvalid_r   <= 1'b0;
      rresp_r    <= RESP_OKAY;
      rdata_r    <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb0_q   <= 1'b0;
      nh_r       <= '0;
      irq_en     <= '0;
      cnt[0]     <= RST_LOAD;
      cnt[1]     <= RST_LOAD;
      corerstn_r <= 2'b00;
      intrs_q    <= 2'b00;
      rise_q     <= 2'b00;
      status     <= 2'b00;
      irq_r      <= 1'b0;
    end else begin
      if (bvalid_r && s_axilite_bready) begin
        awready_r <= 1'b1;
        wready_r  <= 1'b1;
      end else begin
        if (aw_hs) awready_r <= 1'b0;
        if (w_hs)  wready_r  <= 1'b0;
      end
      if (aw_hs) awaddr_q <= s_axilite_awaddr;
      if (w_hs) begin
        wdata_q  <= s_axilite_wdata[5:0];
        wstrb0_q <= s_axilite_wstrb[0];
      end
      if (commit) begin
        bvalid_r <= 1'b1;
        bresp_r  <= wr_bad ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axilite_bready) begin
        bvalid_r <= 1'b0;
      end

      if (ar_hs) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_val;
        rresp_r  <= rd_bad ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axilite_rready) begin
        rvalid_r <= 1'b0;
      end

      if (ctrl_wr) begin
        nh_r   <= wdat[2:0];
        irq_en <= wdat[5:4];
      end

      // A reload always restarts the full hold, even mid-count.
      for (int i = 0; i < 2; i++) begin
        if (rst_set[i])
          cnt[i] <= RST_LOAD;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - CW'(1);
        corerstn_r[i] <= (cnt[i] == '0);
      end

      intrs_q <= intrs;
      rise_q  <= intrs & ~intrs_q;
      status  <= (status & ~clr) | rise_q;
      irq_r   <= |(status & irq_en);
    end
  end

  assign s_axilite_awready = awready_r;
  assign s_axilite_wready  = wready_r;
  assign s_axilite_bvalid  = bvalid_r;
  assign s_axilite_bresp   = bresp_r;
  assign s_axilite_arready = ~rvalid_r;
  assign s_axilite_rvalid  = rvalid_r;
  assign s_axilite_rresp   = rresp_r;
  assign s_axilite_rdata   = rdata_r;
  assign nohype_settings   = nh_r;
  assign corerstn          = corerstn_r;
  assign irq               = irq_r;

  assign unused_ok = ^{s_axilite_wdata[31:6], s_axilite_wstrb[3:1],
                       s_axilite_awaddr[1:0], s_axilite_araddr[1:0]};
endmodule

// File: tb/tb_pardcore_ctrl_regs.sv
// Directed bench for pardcore_ctrl_regs: register-map vector table plus timing-sensitive sequences.
module tb_pardcore_ctrl_regs;
  logic        coreclk = 1'b0;
  logic        corersts = 1'b1;
  logic [11:0] awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [1:0]  intrs = '0;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp, corerstn;
  logic [31:0] rdata;
  logic [2:0]  nohype;

  int tests = 0, failed = 0;
  int low0 = 0, low1 = 0;
  logic mon_en = 1'b0;

  pardcore_ctrl_regs dut (
    .coreclk(coreclk), .corersts(corersts),
    .s_axilite_awaddr(awaddr), .s_axilite_awvalid(awvalid), .s_axilite_awready(awready),
    .s_axilite_wdata(wdata), .s_axilite_wstrb(wstrb), .s_axilite_wvalid(wvalid), .s_axilite_wready(wready),
    .s_axilite_bresp(bresp), .s_axilite_bvalid(bvalid), .s_axilite_bready(bready),
    .s_axilite_araddr(araddr), .s_axilite_arvalid(arvalid), .s_axilite_arready(arready),
    .s_axilite_rdata(rdata), .s_axilite_rresp(rresp), .s_axilite_rvalid(rvalid), .s_axilite_rready(rready),
    .nohype_settings(nohype), .corerstn(corerstn), .intrs(intrs), .irq(irq)
  );

  always #5 coreclk = ~coreclk;

  always @(negedge coreclk) begin
    if (mon_en) begin
      if (!corerstn[0]) low0++;
      if (!corerstn[1]) low1++;
    end
  end

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Tasks start and end just after a falling edge.
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    logic aw_hs, w_hs;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge coreclk); n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    while (!bvalid && n < 20) begin
      @(negedge coreclk); n++;
    end
    if (!bvalid) begin
      tests++; failed++;
      $display("FAIL write_timeout addr %h: no B response, required one within 20 cycles", a);
      awvalid = 1'b0; wvalid = 1'b0; resp = 2'bxx;
    end else begin
      resp = bresp;
      bready = 1'b1;
      @(negedge coreclk);
      bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    logic hs;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      hs = arready;
      @(negedge coreclk); n++;
      if (hs) arvalid = 1'b0;
    end
    while (!rvalid && n < 20) begin
      @(negedge coreclk); n++;
    end
    if (!rvalid) begin
      tests++; failed++;
      $display("FAIL read_timeout addr %h: no R response, required one within 20 cycles", a);
      arvalid = 1'b0; d = 'x; resp = 2'bxx;
    end else begin
      d = rdata; resp = rresp;
      rready = 1'b1;
      @(negedge coreclk);
      rready = 1'b0;
    end
  endtask

  initial begin
    vec_t        vecs [16];
    logic [31:0] rd;
    logic [1:0]  rs;
    int          n;

    //           wr    addr     data           strb  resp   rdata
    vecs[0]  = '{1'b0, 12'h00C, 32'h0,         4'h0, 2'b00, 32'h5041_5244};
    vecs[1]  = '{1'b1, 12'h000, 32'h0000_0012, 4'h1, 2'b00, 32'h0};
    vecs[2]  = '{1'b0, 12'h000, 32'h0,         4'h0, 2'b00, 32'h0000_0012};
    vecs[3]  = '{1'b1, 12'h000, 32'hFFFF_FFFF, 4'hE, 2'b00, 32'h0};
    vecs[4]  = '{1'b0, 12'h000, 32'h0,         4'h0, 2'b00, 32'h0000_0012};
    vecs[5]  = '{1'b1, 12'h00C, 32'h0,         4'hF, 2'b00, 32'h0};
    vecs[6]  = '{1'b0, 12'h00C, 32'h0,         4'h0, 2'b00, 32'h5041_5244};
    vecs[7]  = '{1'b1, 12'h010, 32'h0000_0000, 4'hF, 2'b10, 32'h0};
    vecs[8]  = '{1'b0, 12'h000, 32'h0,         4'h0, 2'b00, 32'h0000_0012};
    vecs[9]  = '{1'b0, 12'h010, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[10] = '{1'b1, 12'h000, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
    vecs[11] = '{1'b0, 12'h000, 32'h0,         4'h0, 2'b00, 32'h0000_0037};
    vecs[12] = '{1'b1, 12'h000, 32'h0000_0035, 4'h1, 2'b00, 32'h0};
    vecs[13] = '{1'b0, 12'h008, 32'h0,         4'h0, 2'b00, 32'h0};
    vecs[14] = '{1'b0, 12'h004, 32'h0,         4'h0, 2'b00, 32'h0};
    vecs[15] = '{1'b1, 12'h100, 32'h0000_0000, 4'hF, 2'b10, 32'h0};

    // Reset values
    repeat (3) @(negedge coreclk);
    check("rst_readys", {awready, wready, arready}, 3'b111);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_resps", {bresp, rresp}, 4'b0000);
    check("rst_rdata", rdata, 32'h0);
    check("rst_nohype", nohype, 3'b000);
    check("rst_corerstn", corerstn, 2'b00);
    check("rst_irq", irq, 1'b0);

    corersts = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge coreclk);
      if (corerstn != 2'b00) break;
      n++;
    end
    check("rst_hold_cycles", n, 16);
    check("corerstn_released", corerstn, 2'b11);

    // W presented three cycles ahead of AW
    wdata = 32'h35; wstrb = 4'h1; wvalid = 1'b1;
    @(negedge coreclk); wvalid = 1'b0;
    check("w_first_wready_low", wready, 1'b0);
    check("w_first_no_b", bvalid, 1'b0);
    @(negedge coreclk); @(negedge coreclk);
    awaddr = 12'h000; awvalid = 1'b1;
    @(negedge coreclk); awvalid = 1'b0;
    check("w_first_bvalid", bvalid, 1'b1);
    check("w_first_bresp", bresp, 2'b00);
    check("w_first_nohype", nohype, 3'b101);
    check("w_first_awready_low", awready, 1'b0);
    bready = 1'b1;
    @(negedge coreclk); bready = 1'b0;
    check("w_first_b_done", bvalid, 1'b0);
    check("w_first_readys_back", {awready, wready}, 2'b11);
    @(negedge coreclk);
    check("w_first_single_b", bvalid, 1'b0);
    axi_read(12'h000, rd, rs);
    check("w_first_readback", rd, 32'h35);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
        check($sformatf("vec%0d_bresp", i), rs, vecs[i].resp);
      end else begin
        axi_read(vecs[i].addr, rd, rs);
        check($sformatf("vec%0d_rresp", i), rs, vecs[i].resp);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      end
    end
    check("vec_nohype_final", nohype, 3'b101);

    // Interrupt: status two edges after the rise, irq one edge later
    intrs = 2'b01;
    @(negedge coreclk); check("irq_edge1", irq, 1'b0);
    @(negedge coreclk); check("irq_edge2", irq, 1'b0);
    @(negedge coreclk); check("irq_edge3", irq, 1'b1);
    intrs = 2'b00;
    axi_read(12'h008, rd, rs);
    check("intr_status", rd, 32'h1);

    // W1C commits on the same edge that a new rise sets status
    intrs = 2'b01;
    @(negedge coreclk);
    awaddr = 12'h008; wdata = 32'h1; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge coreclk);
    awvalid = 1'b0; wvalid = 1'b0; intrs = 2'b00; araddr = 12'h008; arvalid = 1'b1;
    @(negedge coreclk);
    arvalid = 1'b0; bready = 1'b0;
    check("set_wins_rvalid", rvalid, 1'b1);
    check("set_wins_status", rdata, 32'h1);
    rready = 1'b1;
    @(negedge coreclk); rready = 1'b0;

    axi_write(12'h008, 32'h1, 4'h1, rs);
    check("w1c_bresp", rs, 2'b00);
    check("w1c_irq", irq, 1'b0);
    axi_read(12'h008, rd, rs);
    check("w1c_status", rd, 32'h0);

    // Core 1 reset, reloaded at hold cycle 10
    mon_en = 1'b1;
    awaddr = 12'h004; wdata = 32'h2; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge coreclk); awvalid = 1'b0; wvalid = 1'b0;
    repeat (9) @(negedge coreclk);
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge coreclk); awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (corerstn[1]) break;
      @(negedge coreclk);
    end
    bready = 1'b0; mon_en = 1'b0;
    check("core1_low_cycles", low1, 26);
    check("core0_unaffected", low0, 0);

    // Stalled responses, then reset while both are pending
    araddr = 12'h000; arvalid = 1'b1;
    awaddr = 12'h000; wdata = 32'h07; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge coreclk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("hold_nohype", nohype, 3'b111);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d_flags", k), {rvalid, bvalid, bresp, rresp, arready, awready}, 8'b1100_0000);
      check($sformatf("hold%0d_rdata", k), rdata, 32'h35);
      @(negedge coreclk);
    end
    corersts = 1'b1;
    @(negedge coreclk);
    check("mid_rst_readys", {awready, wready, arready}, 3'b111);
    check("mid_rst_valids", {bvalid, rvalid}, 2'b00);
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_outputs", {nohype, corerstn, irq}, 6'b000_00_0);
    corersts = 1'b0;
    @(negedge coreclk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
